// File: rtl/pool_stream_unit.sv
// pool_stream_unit: streaming feature-map stage. STRIDE=1 registers beats straight through;
// STRIDE=2 performs 2x2 max-pool with stride 2: even rows are reduced horizontally into a
// line buffer, odd rows combine with the buffered row and emit one half-width beat.
// Build option: define POOL_RELU_EN to clamp every negative output lane to zero.
module pool_stream_unit #(
    parameter int LANES     = 16,
    parameter int PW        = 16,
    parameter int ROW_BEATS = 14,
    parameter int ROWS      = 208,
    parameter int CHANNELS  = 32,
    parameter int STRIDE    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*PW-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*PW-1:0]   out_data,
    output logic                  done
);

    localparam int HALF   = LANES / 2;
    localparam int DW     = LANES * PW;
    localparam int HW     = HALF * PW;
    localparam int BEAT_W = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(ROW_BEATS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [CHAN_W-1:0] CHAN_LAST = CHAN_W'(CHANNELS - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [ROW_W-1:0]  ROW_ONE   = ROW_W'(1);
    localparam logic [CHAN_W-1:0] CHAN_ONE  = CHAN_W'(1);

    logic              armed_q;
    logic              in_done_q;
    logic [BEAT_W-1:0] beat_q;
    logic [ROW_W-1:0]  row_q;
    logic [CHAN_W-1:0] chan_q;
    logic              out_valid_q;
    logic [DW-1:0]     out_data_q;
    logic              done_q;

    logic [HW-1:0]     lbuf [ROW_BEATS];
    logic [HW-1:0]     lbuf_rd;
    logic [HW-1:0]     hmax;
    logic [DW-1:0]     pooled;

    logic              accept;
    logic              emits;
    logic              buffer_row;
    logic              frame_last;
    logic              finish;

    // Signed PW-bit maximum; ties return the shared value, no width growth.
    function automatic logic [PW-1:0] smax(input logic [PW-1:0] a, input logic [PW-1:0] b);
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

    // Optional output clamp applied after pooling, purely combinational.
    function automatic logic [PW-1:0] relu(input logic [PW-1:0] v);
`ifdef POOL_RELU_EN
        return v[PW-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Even rows in pooling mode only fill the line buffer, so they never wait on the output.
    assign buffer_row = (STRIDE == 2) && !row_q[0];
    assign emits      = (STRIDE == 1) || row_q[0];
    assign in_ready   = armed_q && !in_done_q && (buffer_row || !out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign frame_last = (beat_q == BEAT_LAST) && (row_q == ROW_LAST) && (chan_q == CHAN_LAST);
    assign finish     = armed_q && in_done_q && (!out_valid_q || out_ready);
    assign lbuf_rd    = lbuf[beat_q];

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign done       = done_q;

    // Horizontal pair maxima and the output beat the current input would produce.
    always_comb begin
        hmax   = '0;
        pooled = '0;
        for (int j = 0; j < HALF; j++) begin
            hmax[j*PW +: PW] = smax(in_data[2*j*PW +: PW], in_data[(2*j+1)*PW +: PW]);
        end
        if (STRIDE == 1) begin
            for (int k = 0; k < LANES; k++) begin
                pooled[k*PW +: PW] = relu(in_data[k*PW +: PW]);
            end
        end else begin
            for (int j = 0; j < HALF; j++) begin
                pooled[j*PW +: PW] = relu(smax(lbuf_rd[j*PW +: PW], hmax[j*PW +: PW]));
            end
        end
    end

    // Line buffer holds the horizontal maxima of the most recent even row; no reset needed.
    always_ff @(posedge clk) begin
        if (accept && buffer_row) begin
            lbuf[beat_q] <= hmax;
        end
    end

    // Frame sequencing, position counters and the registered output beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q     <= 1'b0;
            in_done_q   <= 1'b0;
            beat_q      <= '0;
            row_q       <= '0;
            chan_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (start && !armed_q) begin
                armed_q   <= 1'b1;
                in_done_q <= 1'b0;
                beat_q    <= '0;
                row_q     <= '0;
                chan_q    <= '0;
            end

            if (accept) begin
                if (beat_q == BEAT_LAST) begin
                    beat_q <= '0;
                    if (row_q == ROW_LAST) begin
                        row_q  <= '0;
                        chan_q <= (chan_q == CHAN_LAST) ? '0 : chan_q + CHAN_ONE;
                    end else begin
                        row_q <= row_q + ROW_ONE;
                    end
                end else begin
                    beat_q <= beat_q + BEAT_ONE;
                end
                if (frame_last) begin
                    in_done_q <= 1'b1;
                end
            end

            // A new result replaces an accepted one in the same cycle, so there is no bubble.
            if (accept && emits) begin
                out_valid_q <= 1'b1;
                out_data_q  <= pooled;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            // All inputs consumed and the last result drained (or none pending): close frame.
            if (finish) begin
                done_q    <= 1'b1;
                armed_q   <= 1'b0;
                in_done_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pool_stream_unit.sv
// Bench for pool_stream_unit: three instances (tiny 2x2 pool, small 2x2 pool with odd ROWS,
// small pass-through) exercised by a vector table, a randomized scoreboard run and
// hand-written backpressure / reset sequences.
module tb_pool_stream_unit;

    localparam int DW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic a_start, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_done;
    logic [DW-1:0] a_in_data, a_out_data;
    logic b_start, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_done;
    logic [DW-1:0] b_in_data, b_out_data;
    logic c_start, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_done;
    logic [DW-1:0] c_in_data, c_out_data;

    pool_stream_unit #(.LANES(4), .PW(16), .ROW_BEATS(1), .ROWS(2), .CHANNELS(1), .STRIDE(2))
    u_a (.clk(clk), .rst_n(rst_n), .start(a_start), .in_valid(a_in_valid), .in_ready(a_in_ready),
         .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
         .out_data(a_out_data), .done(a_done));

    pool_stream_unit #(.LANES(4), .PW(16), .ROW_BEATS(3), .ROWS(3), .CHANNELS(2), .STRIDE(2))
    u_b (.clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
         .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
         .out_data(b_out_data), .done(b_done));

    pool_stream_unit #(.LANES(4), .PW(16), .ROW_BEATS(2), .ROWS(2), .CHANNELS(2), .STRIDE(1))
    u_c (.clk(clk), .rst_n(rst_n), .start(c_start), .in_valid(c_in_valid), .in_ready(c_in_ready),
         .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
         .out_data(c_out_data), .done(c_done));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pack(input int l0, input int l1, input int l2, input int l3);
        return {l3[15:0], l2[15:0], l1[15:0], l0[15:0]};
    endfunction

    function automatic logic signed [15:0] rl(input logic signed [15:0] v);
`ifdef POOL_RELU_EN
        return (v < 0) ? 16'sd0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [DW-1:0] rl4(input logic [DW-1:0] x);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) r[k*16 +: 16] = rl(x[k*16 +: 16]);
        return r;
    endfunction

    function automatic logic [15:0] rand_pix();
        if ($urandom % 2 == 0) return 16'($urandom);
        return 16'($urandom_range(0, 6)) - 16'd3;
    endfunction

    // Instance A vector table: two rows in, one pooled beat out.
    typedef struct packed {
        logic [DW-1:0] row0;
        logic [DW-1:0] row1;
        logic [DW-1:0] exp_plain;
        logic [DW-1:0] exp_relu;
    } vec_t;

    // Instance B frame: pixels indexed [channel][row][beat][lane].
    logic signed [15:0] pix [2][3][3][4];

    task automatic run_b(input bit stall_mode);
        logic [DW-1:0] in_q[$];
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] beat, held;
        logic signed [15:0] m, x;
        int done_cnt, tail, stall_cnt, slow_cnt;
        bit pend;
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 3; r++)
                for (int b = 0; b < 3; b++)
                    for (int l = 0; l < 4; l++) pix[c][r][b][l] = rand_pix();
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 3; r++)
                for (int b = 0; b < 3; b++) begin
                    for (int l = 0; l < 4; l++) beat[l*16 +: 16] = pix[c][r][b][l];
                    in_q.push_back(beat);
                end
        // Each 2x2 window max; the unpaired last row contributes nothing.
        for (int c = 0; c < 2; c++)
            for (int pr = 0; pr < 3 / 2; pr++)
                for (int b = 0; b < 3; b++) begin
                    beat = '0;
                    for (int j = 0; j < 2; j++) begin
                        m = pix[c][2*pr][b][2*j];
                        for (int dr = 0; dr < 2; dr++)
                            for (int dl = 0; dl < 2; dl++) begin
                                x = pix[c][2*pr+dr][b][2*j+dl];
                                if (x > m) m = x;
                            end
                        beat[j*16 +: 16] = rl(m);
                    end
                    exp_q.push_back(beat);
                end
        @(negedge clk) b_start = 1'b1;
        @(negedge clk) b_start = 1'b0;
        done_cnt = 0; tail = 0; stall_cnt = 0; slow_cnt = 0; pend = 1'b0; held = '0;
        for (int cyc = 0; cyc < 400 && tail < 4; cyc++) begin
            @(negedge clk);
            if (b_done) begin
                done_cnt++;
                check("b_done_after_drain", {62'd0, in_q.size() == 0, exp_q.size() == 0}, 64'd3);
            end
            if (done_cnt > 0) tail++;
            b_start = !stall_mode && in_q.size() > 0 && ($urandom % 8 == 0);
            if (!pend) begin
                if (in_q.size() > 0 && (stall_mode || $urandom % 4 != 0)) begin
                    b_in_valid = 1'b1;
                    b_in_data  = in_q[0];
                    pend       = 1'b1;
                end else begin
                    b_in_valid = 1'b0;
                end
            end
            if (stall_mode) begin
                if (b_out_valid && stall_cnt < 5) begin
                    if (stall_cnt == 0) held = b_out_data;
                    else check("b_stall_data_stable", b_out_data, held);
                    b_out_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    b_out_ready = 1'b1;
                end
            end else begin
                b_out_ready = ($urandom % 3 != 0);
            end
            #1;
            if (stall_mode && !b_out_ready) check("b_stall_in_ready", b_in_ready, 0);
            if (stall_mode && stall_cnt == 5 && b_out_ready && b_in_valid && !b_in_ready)
                slow_cnt++;
            if (b_in_valid && b_in_ready) begin
                void'(in_q.pop_front());
                pend = 1'b0;
            end
            if (b_out_valid && b_out_ready) begin
                if (exp_q.size() == 0) check("b_extra_output", b_out_valid, 0);
                else check("b_out_data", b_out_data, exp_q.pop_front());
            end
        end
        b_start = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
        check("b_done_count", done_cnt, 1);
        check("b_all_in_taken", in_q.size(), 0);
        check("b_all_out_seen", exp_q.size(), 0);
        check("b_idle_in_ready", b_in_ready, 0);
        if (stall_mode) begin
            check("b_stall_cycles", stall_cnt, 5);
            check("b_post_stall_throughput", slow_cnt, 0);
        end
    endtask

    initial begin
        vec_t vecs[4];
        logic [DW-1:0] exp, cb[8];

        rst_n = 1'b0;
        a_start = 0; a_in_valid = 0; a_out_ready = 0; a_in_data = '0;
        b_start = 0; b_in_valid = 0; b_out_ready = 0; b_in_data = '0;
        c_start = 0; c_in_valid = 0; c_out_ready = 0; c_in_data = '0;

        vecs[0] = '{pack(1, -5, 3, 2), pack(4, 0, -7, 9), pack(4, 9, 0, 0), pack(4, 9, 0, 0)};
        vecs[1] = '{pack(-3, -8, -1, -2), pack(-4, -6, -9, -5), pack(-3, -1, 0, 0),
                    pack(0, 0, 0, 0)};
        vecs[2] = '{pack(7, 7, -2, -2), pack(7, 7, -2, -2), pack(7, -2, 0, 0), pack(7, 0, 0, 0)};
        vecs[3] = '{pack(-32768, 32767, -32768, -32768), pack(-32768, -32768, -1, -32768),
                    pack(32767, -1, 0, 0), pack(32767, 0, 0, 0)};

        repeat (3) @(negedge clk);
        check("rst_a_in_ready", a_in_ready, 0);
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_done", a_done, 0);
        check("rst_a_out_data", a_out_data, 0);
        check("rst_b_in_ready", b_in_ready, 0);
        check("rst_b_out_valid", b_out_valid, 0);
        check("rst_c_in_ready", c_in_ready, 0);
        check("rst_c_out_data", c_out_data, 0);
        rst_n = 1'b1;

        // Table-driven: tiny 2x2 pool, one output beat per frame.
        for (int i = 0; i < 4; i++) begin
`ifdef POOL_RELU_EN
            exp = vecs[i].exp_relu;
`else
            exp = vecs[i].exp_plain;
`endif
            @(negedge clk) a_start = 1'b1;
            @(negedge clk) a_start = 1'b0;
            check("a_ready_even_row", a_in_ready, 1);
            a_in_valid = 1'b1; a_in_data = vecs[i].row0;
            @(negedge clk);
            check("a_no_out_even_row", a_out_valid, 0);
            a_in_data = vecs[i].row1;
            @(negedge clk);
            a_in_valid = 1'b0;
            check("a_out_valid", a_out_valid, 1);
            check("a_out_data", a_out_data, exp);
            check("a_ready_after_last", a_in_ready, 0);
            a_out_ready = 1'b1;
            @(negedge clk);
            check("a_done_pulse", a_done, 1);
            check("a_out_valid_clear", a_out_valid, 0);
            a_out_ready = 1'b0;
            @(negedge clk);
            check("a_done_single", a_done, 0);
            check("a_idle", a_in_ready, 0);
        end

        // Randomized frames with start pulses mid-frame, then the backpressure sequence.
        for (int f = 0; f < 3; f++) run_b(1'b0);
        run_b(1'b1);

        // Pass-through: stream 4 of 8 beats, reset mid-frame, then a full clean frame.
        for (int k = 0; k < 8; k++) cb[k] = {$urandom, $urandom};
        @(negedge clk) c_start = 1'b1;
        @(negedge clk) c_start = 1'b0;
        c_out_ready = 1'b1; c_in_valid = 1'b1; c_in_data = cb[0];
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("c_pre_reset_data", c_out_data, rl4(cb[k-1]));
            c_in_data = cb[k];
        end
        rst_n = 1'b0;
        #1;
        check("c_rst_out_valid", c_out_valid, 0);
        check("c_rst_in_ready", c_in_ready, 0);
        check("c_rst_out_data", c_out_data, 0);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("c_no_accept_before_start", {c_in_ready, c_out_valid}, 0);
        end
        for (int k = 0; k < 8; k++) cb[k] = {$urandom, $urandom};
        c_start = 1'b1;
        @(negedge clk) c_start = 1'b0;
        c_in_data = cb[0];
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("c_stream_valid", c_out_valid, 1);
            check("c_stream_data", c_out_data, rl4(cb[k-1]));
            if (k < 8) c_in_data = cb[k];
            else c_in_valid = 1'b0;
        end
        @(negedge clk);
        check("c_done_pulse", c_done, 1);
        @(negedge clk);
        check("c_done_single", c_done, 0);
        check("c_idle", c_in_ready, 0);
        c_out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
